// File: rtl/hcp_round_sequencer.sv
// Validates the opened-round challenge lists from the hidden-challenge parser and
// walks every round in order, emitting one descriptor beat per round over valid/ready.
module hcp_round_sequencer #(
  parameter int NUM_ROUNDS  = 8,
  parameter int NUM_OPEN    = 4,
  parameter int IDX_W       = 5,
  parameter int NUM_PARTIES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seq_start,
  input  logic [NUM_OPEN*IDX_W-1:0] Lc,
  input  logic [NUM_OPEN*IDX_W-1:0] Lp,
  output logic                      rnd_valid,
  input  logic                      rnd_ready,
  output logic [IDX_W-1:0]          rnd_index,
  output logic                      rnd_open,
  output logic [IDX_W-1:0]          rnd_party,
  output logic                      rnd_last,
  output logic [NUM_ROUNDS-1:0]     open_mask,
  output logic                      seq_busy,
  output logic                      seq_end,
  output logic                      seq_err
);

  typedef enum logic [1:0] {IDLE, CHECK, EMIT, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_R = IDX_W'(NUM_ROUNDS - 1);

  state_t           state;
  logic [IDX_W-1:0] lc_q [NUM_OPEN];
  logic [IDX_W-1:0] lp_q [NUM_OPEN];

  logic [NUM_ROUNDS-1:0] mask_c;
  logic                  err_c;
  logic [IDX_W-1:0]      nxt_r;
  logic                  nxt_open;
  logic [IDX_W-1:0]      nxt_party;

  // Validation, mask and next-beat fields all derive from the captured lists only.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mask_c    = '0;
    err_c     = 1'b0;
    nxt_r     = (state == CHECK) ? '0 : rnd_index + 1'b1;
    nxt_open  = 1'b0;
    nxt_party = '0;
    for (int k = 0; k < NUM_OPEN; k++) begin
      if (32'(lc_q[k]) >= NUM_ROUNDS)  err_c = 1'b1;
      if (32'(lp_q[k]) >= NUM_PARTIES) err_c = 1'b1;
      for (int j = k + 1; j < NUM_OPEN; j++) begin
        if (lc_q[k] == lc_q[j]) err_c = 1'b1;
      end
      // Uniqueness of Lc entries makes the OR-merge select exactly one party.
      if (lc_q[k] == nxt_r) begin
        nxt_open  = 1'b1;
        nxt_party = nxt_party | lp_q[k];
      end
    end
    for (int r = 0; r < NUM_ROUNDS; r++) begin
      for (int k = 0; k < NUM_OPEN; k++) begin
        if (32'(lc_q[k]) == 32'(r)) mask_c[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      // NOTE: the capture registers are tiny flop arrays, not RAM, so resetting them is cheap and defined.
      for (int k = 0; k < NUM_OPEN; k++) begin
        lc_q[k] <= '0;
        lp_q[k] <= '0;
      end
      rnd_valid <= 1'b0;
      rnd_index <= '0;
      rnd_open  <= 1'b0;
      rnd_party <= '0;
      rnd_last  <= 1'b0;
      open_mask <= '0;
      seq_busy  <= 1'b0;
      seq_end   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (seq_start && !seq_end) begin
            for (int k = 0; k < NUM_OPEN; k++) begin
              lc_q[k] <= Lc[NUM_OPEN*IDX_W-1-k*IDX_W -: IDX_W];
              lp_q[k] <= Lp[NUM_OPEN*IDX_W-1-k*IDX_W -: IDX_W];
            end
            seq_busy <= 1'b1;
            state    <= CHECK;
          end
        end

        CHECK: begin
          if (!seq_start) begin
            seq_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            open_mask <= mask_c;
            if (err_c) begin
              seq_err  <= 1'b1;
              seq_end  <= 1'b1;
              seq_busy <= 1'b0;
              state    <= DONE;
            end else begin
              rnd_valid <= 1'b1;
              rnd_index <= nxt_r;
              rnd_open  <= nxt_open;
              rnd_party <= nxt_party;
              rnd_last  <= (nxt_r == LAST_R);
              state     <= EMIT;
            end
          end
        end

        EMIT: begin
          // Abort takes priority over a handshake on the same edge.
          if (!seq_start || (rnd_ready && rnd_last)) begin
            rnd_valid <= 1'b0;
            rnd_index <= '0;
            rnd_open  <= 1'b0;
            rnd_party <= '0;
            rnd_last  <= 1'b0;
            seq_busy  <= 1'b0;
            seq_end   <= seq_start;
            state     <= seq_start ? DONE : IDLE;
          end else if (rnd_ready) begin
            rnd_index <= nxt_r;
            rnd_open  <= nxt_open;
            rnd_party <= nxt_party;
            rnd_last  <= (nxt_r == LAST_R);
          end
        end

        DONE: begin
          if (!seq_start) begin
            seq_end <= 1'b0;
            seq_err <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hcp_round_sequencer.sv
// Directed plus randomized bench for hcp_round_sequencer, checked against a
// list-level reference model of the challenge rules.
module tb_hcp_round_sequencer;

  localparam int NR = 8;
  localparam int NO = 4;
  localparam int IW = 5;
  localparam int NP = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             seq_start;
  logic [NO*IW-1:0] Lc;
  logic [NO*IW-1:0] Lp;
  logic             rnd_valid;
  logic             rnd_ready;
  logic [IW-1:0]    rnd_index;
  logic             rnd_open;
  logic [IW-1:0]    rnd_party;
  logic             rnd_last;
  logic [NR-1:0]    open_mask;
  logic             seq_busy;
  logic             seq_end;
  logic             seq_err;

  hcp_round_sequencer #(
    .NUM_ROUNDS(NR), .NUM_OPEN(NO), .IDX_W(IW), .NUM_PARTIES(NP)
  ) dut (
    .clk(clk), .reset(reset), .seq_start(seq_start), .Lc(Lc), .Lp(Lp),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_index(rnd_index),
    .rnd_open(rnd_open), .rnd_party(rnd_party), .rnd_last(rnd_last),
    .open_mask(open_mask), .seq_busy(seq_busy), .seq_end(seq_end), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int m_lc    [NO];
  int m_lp    [NO];
  int m_stall [NR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the challenge rules stated directly on the integer lists.
  function automatic bit model_err();
    model_err = 1'b0;
    for (int k = 0; k < NO; k++) begin
      if (m_lc[k] >= NR || m_lp[k] >= NP) model_err = 1'b1;
      for (int j = 0; j < NO; j++)
        if (j != k && m_lc[j] == m_lc[k]) model_err = 1'b1;
    end
  endfunction

  function automatic int model_party(input int r);
    model_party = -1;
    for (int k = 0; k < NO; k++)
      if (m_lc[k] == r) model_party = m_lp[k];
  endfunction

  function automatic logic [31:0] model_mask();
    model_mask = 0;
    for (int k = 0; k < NO; k++)
      if (m_lc[k] < NR) model_mask = model_mask | (32'd1 << m_lc[k]);
  endfunction

  task automatic check_all_zero(input string name);
    check({name, "/valid"}, 32'(rnd_valid), 0);
    check({name, "/index"}, 32'(rnd_index), 0);
    check({name, "/open"},  32'(rnd_open),  0);
    check({name, "/party"}, 32'(rnd_party), 0);
    check({name, "/last"},  32'(rnd_last),  0);
    check({name, "/mask"},  32'(open_mask), 0);
    check({name, "/busy"},  32'(seq_busy),  0);
    check({name, "/end"},   32'(seq_end),   0);
    check({name, "/err"},   32'(seq_err),   0);
  endtask

  // One full run from IDLE; abort_at >= 0 drops seq_start while that round is presented.
  task automatic run_seq(input string name, input int abort_at);
    bit err;
    err = model_err();
    for (int k = 0; k < NO; k++) begin
      Lc[NO*IW-1-k*IW -: IW] = IW'(m_lc[k]);
      Lp[NO*IW-1-k*IW -: IW] = IW'(m_lp[k]);
    end
    seq_start = 1'b1;
    rnd_ready = 1'b0;
    tick();  // E0
    check({name, "/busy_e0"},  32'(seq_busy),  1);
    check({name, "/valid_e0"}, 32'(rnd_valid), 0);
    tick();  // E1
    if (err) begin
      check({name, "/err_end"},   32'(seq_end),   1);
      check({name, "/err_err"},   32'(seq_err),   1);
      check({name, "/err_valid"}, 32'(rnd_valid), 0);
      check({name, "/err_busy"},  32'(seq_busy),  0);
    end else begin
      check({name, "/mask"}, 32'(open_mask), model_mask());
      for (int r = 0; r < NR; r++) begin
        int p;
        p = model_party(r);
        for (int s = 0; s <= m_stall[r]; s++) begin
          rnd_ready = (s == m_stall[r]);
          check($sformatf("%s/r%0d.valid", name, r), 32'(rnd_valid), 1);
          check($sformatf("%s/r%0d.index", name, r), 32'(rnd_index), 32'(r));
          check($sformatf("%s/r%0d.open",  name, r), 32'(rnd_open),  32'(p >= 0));
          check($sformatf("%s/r%0d.party", name, r), 32'(rnd_party), (p >= 0) ? 32'(p) : 0);
          check($sformatf("%s/r%0d.last",  name, r), 32'(rnd_last),  32'(r == NR - 1));
          check($sformatf("%s/r%0d.end",   name, r), 32'(seq_end),   0);
          check($sformatf("%s/r%0d.busy",  name, r), 32'(seq_busy),  1);
          if (r == abort_at && s == m_stall[r]) begin
            seq_start = 1'b0;
            rnd_ready = 1'b0;
            tick();
            check({name, "/abort_valid"}, 32'(rnd_valid), 0);
            check({name, "/abort_end"},   32'(seq_end),   0);
            check({name, "/abort_busy"},  32'(seq_busy),  0);
            tick();
            check({name, "/abort_end2"},  32'(seq_end),   0);
            check({name, "/abort_valid2"},32'(rnd_valid), 0);
            return;
          end
          tick();
        end
      end
      check({name, "/end"},   32'(seq_end),   1);
      check({name, "/err"},   32'(seq_err),   0);
      check({name, "/valid"}, 32'(rnd_valid), 0);
      check({name, "/busy"},  32'(seq_busy),  0);
    end
    // Holding seq_start high must not re-arm a second run.
    repeat (3) begin
      tick();
      check({name, "/hold_valid"}, 32'(rnd_valid), 0);
      check({name, "/hold_end"},   32'(seq_end),   1);
      check({name, "/hold_busy"},  32'(seq_busy),  0);
    end
    seq_start = 1'b0;
    tick();
    check({name, "/clr_end"}, 32'(seq_end), 0);
    check({name, "/clr_err"}, 32'(seq_err), 0);
  endtask

  task automatic set_lists(input int l0, l1, l2, l3, input int p0, p1, p2, p3);
    m_lc[0] = l0; m_lc[1] = l1; m_lc[2] = l2; m_lc[3] = l3;
    m_lp[0] = p0; m_lp[1] = p1; m_lp[2] = p2; m_lp[3] = p3;
    for (int r = 0; r < NR; r++) m_stall[r] = 0;
  endtask

  initial begin
    reset     = 1'b0;
    seq_start = 1'b0;
    rnd_ready = 1'b0;
    Lc        = '0;
    Lp        = '0;
    #12;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    set_lists(3, 0, 6, 1, 2, 15, 7, 9);
    run_seq("nominal", -1);
    check("nominal/mask_const", 32'(open_mask), 32'h4B);

    set_lists(3, 0, 6, 1, 2, 15, 7, 9);
    m_stall[3] = 3;
    run_seq("backpressure", -1);

    set_lists(2, 2, 5, 1, 2, 15, 7, 9);
    run_seq("err_dup", -1);
    set_lists(2, 9, 5, 1, 2, 15, 7, 9);
    run_seq("err_lc_range", -1);
    set_lists(3, 0, 6, 1, 2, 16, 7, 9);
    run_seq("err_lp_range", -1);

    set_lists(7, 5, 2, 4, 0, 11, 3, 14);
    run_seq("rearm_new", -1);
    check("rearm_new/mask_const", 32'(open_mask), 32'hB4);

    set_lists(3, 0, 6, 1, 2, 15, 7, 9);
    run_seq("abort_r4", 4);

    // Asynchronous reset while beats are flowing.
    set_lists(3, 0, 6, 1, 2, 15, 7, 9);
    seq_start = 1'b1;
    rnd_ready = 1'b1;
    repeat (4) tick();
    check("rst_mid/valid_before", 32'(rnd_valid), 1);
    #2 reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    seq_start = 1'b0;
    rnd_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_seq("after_reset", -1);

    for (int it = 0; it < 24; it++) begin
      int rs [NR];
      int mode;
      for (int i = 0; i < NR; i++) rs[i] = i;
      for (int i = NR - 1; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(0, i));
        t = rs[i]; rs[i] = rs[j]; rs[j] = t;
      end
      for (int k = 0; k < NO; k++) begin
        m_lc[k] = rs[k];
        m_lp[k] = int'($urandom_range(0, NP - 1));
      end
      for (int r = 0; r < NR; r++) m_stall[r] = int'($urandom_range(0, 2));
      mode = int'($urandom_range(0, 5));
      if (mode == 1) m_lc[1] = m_lc[3];
      if (mode == 2) m_lc[$urandom_range(0, NO - 1)] = int'($urandom_range(NR, 31));
      if (mode == 3) m_lp[$urandom_range(0, NO - 1)] = int'($urandom_range(NP, 31));
      run_seq($sformatf("rand%0d", it), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hcp_round_sequencer.md
# hcp_round_sequencer

Downstream consumer of the verify-side hidden-challenge parser. It takes the packed challenge lists `Lc` (opened rounds) and `Lp` (hidden party per opened round) once the parser signals completion. It validates them and builds an opened-round mask, then walks every round in order. For each round it emits one descriptor beat (round index, opened/closed flag, hidden party) to the per-round verification engine over a valid/ready handshake.

## Interface
- `NUM_ROUNDS`, default 8: rounds per proof; also the width of `open_mask`.
- `NUM_OPEN`, default 4: number of entries in `Lc` and in `Lp`.
- `IDX_W`, default 5: width of each `Lc`/`Lp` entry and of the index outputs.
- `NUM_PARTIES`, default 16: exclusive upper bound for `Lp` entries.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `seq_start`  in  1  level request; driven from the parser's `HCP_end`.
- `Lc`  in  NUM_OPEN*IDX_W  opened-round list; entry k = bits [NUM_OPEN*IDX_W-1-k*IDX_W -: IDX_W]; entry 0 is the MSBs.
- `Lp`  in  NUM_OPEN*IDX_W  hidden-party list; same packing; entry k pairs with `Lc` entry k.
- `rnd_valid`  out  1  descriptor beat valid.
- `rnd_ready`  in  1  downstream accepts the beat.
- `rnd_index`  out  IDX_W  round number of the current beat.
- `rnd_open`  out  1  round is in `Lc`.
- `rnd_party`  out  IDX_W  paired `Lp` entry when `rnd_open` = 1; otherwise 0.
- `rnd_last`  out  1  beat is for round NUM_ROUNDS-1.
- `open_mask`  out  NUM_ROUNDS  bit r set when round r is in `Lc`.
- `seq_busy`  out  1  high in CHECK and EMIT.
- `seq_end`  out  1  sequence complete (success or error); level signal.
- `seq_err`  out  1  challenge lists invalid; valid while `seq_end` = 1.

## Operation
- **States:** IDLE, CHECK, EMIT, DONE.
- **IDLE:**
  - If `seq_start` = 1 and `seq_end` = 0, capture `Lc` and `Lp` into internal registers and go to CHECK.
  - Inputs are not sampled after capture.
- **CHECK** (one cycle):
  - Set `open_mask` from the captured `Lc`.
  - Set the error flag if any of these holds: an `Lc` entry ≥ NUM_ROUNDS; two `Lc` entries are equal; an `Lp` entry ≥ NUM_PARTIES.
  - On error: `seq_err` ← 1, `seq_end` ← 1, go to DONE; no beats are emitted.
  - Otherwise: round counter r ← 0, go to EMIT.
- **EMIT:**
  - Drive `rnd_valid` = 1, `rnd_index` = r, `rnd_open` = `open_mask`[r], `rnd_last` = (r == NUM_ROUNDS-1).
  - `rnd_party` = `Lp` entry k, where k is the `Lc` entry equal to r. CHECK guarantees k is unique. Drive 0 if there is no such entry.
  - On `rnd_valid` & `rnd_ready`:
    - if `rnd_last`: go to DONE, `seq_end` ← 1;
    - else r ← r+1.
  - While `rnd_ready` = 0, all `rnd_*` outputs hold stable.
- **DONE:**
  - Hold `seq_end`, `seq_err` and `open_mask`.
  - When `seq_start` = 0: clear `seq_end` and `seq_err`, go to IDLE.
- **Abort:** `seq_start` = 0 in CHECK or EMIT → go to IDLE next edge, `rnd_valid` ← 0, `seq_end` stays 0, `open_mask` holds.
- **Re-arm:** a new run requires `seq_start` to go low and then high again. This matches the parser's `HCP_end` level protocol.
- **Counter width:** r is IDX_W bits wide. It never exceeds NUM_ROUNDS-1.

## Timing
- **Reset values** (asynchronous, `reset` = 0): state IDLE; `rnd_valid`, `rnd_open`, `rnd_last`, `seq_busy`, `seq_end`, `seq_err` = 0; `rnd_index`, `rnd_party` = 0; `open_mask` = 0; captured lists = 0.
- **Reset mid-operation:** all outputs go to their reset values immediately; no beat is completed.
- **Edge numbering:** E0 = the edge at which `seq_start` is sampled high in IDLE (capture).
- **Start latency:** CHECK is active after E0. `rnd_valid` is first high after E1.
- **Error path:** `seq_end` = `seq_err` = 1 after E1.
- **Throughput:** one beat per cycle while `rnd_ready` = 1.
- **Full run, ready held high:** beats are accepted at E2..E(NUM_ROUNDS+1); `seq_end` = 1 after E(NUM_ROUNDS+1), i.e. E9 for the defaults.
- **`rnd_valid`:** registered; it never depends combinationally on `rnd_ready`.
- **`seq_busy`:** high from after E0 until the edge that enters DONE or IDLE.

## Test plan
- **Nominal run:** `Lc` = {3,0,6,1}, `Lp` = {2,15,7,9}, `rnd_ready` = 1 → `open_mask` = 0x4B. Beats r0..r7: open/party = 1/15, 1/9, 0/0, 1/2, 0/0, 0/0, 1/7, 0/0. `rnd_last` only on r7. `seq_end` = 1 after E9, `seq_err` = 0.
- **Backpressure:** same inputs, `rnd_ready` = 0 for 3 cycles while r3 is presented → r3 fields stay stable (party 2). No beat is skipped or duplicated. `seq_end` is delayed by exactly 3 cycles.
- **Errors:**
  - `Lc` = {2,2,5,1} → `seq_end` = `seq_err` = 1 after E1; `rnd_valid` never rises.
  - Repeat with an `Lc` entry of 9, then with an `Lp` entry of 16 → same response.
- **Handshake re-arm:** hold `seq_start` high after `seq_end` → no second run. Drop `seq_start` for 1 cycle → `seq_end`/`seq_err` clear. Raise it with new lists → a fresh run with the new mask.
- **Abort and reset:**
  - Drop `seq_start` during beat r4 → `rnd_valid` = 0 next cycle, `seq_end` stays 0.
  - Pulse `reset` low during EMIT → all outputs 0 asynchronously. A new run afterwards completes normally.
